carry_lookahead_adder4: RTL and testbench
=========================================

Name: carry_lookahead_adder4

Overview:
- Parameterized carry-lookahead adder computing {c_o, s_o} = a_i + b_i + c_i with a single-cycle registered result.
- Carries are formed by two-level lookahead: 4-bit groups with a group-level lookahead unit. There is no ripple chain.
- Used as an arithmetic leaf in datapaths. The default configuration is the 4-bit adder used throughout the verification suite.

Parameters:
- WIDTH, 4, operand width in bits. Legal values are 4, 8, 12 and 16 (a multiple of 4, at most 16). Any other value is an elaboration error.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  operands on a_i/b_i/c_i are valid this cycle.
- a_i  input  WIDTH  operand A, unsigned.
- b_i  input  WIDTH  operand B, unsigned.
- c_i  input  1  carry-in.
- valid_o  output  1  s_o/c_o/p_o/g_o/ov_o hold a new result.
- s_o  output  WIDTH  sum bits.
- c_o  output  1  carry-out (sum bit WIDTH).
- p_o  output  1  block propagate: AND of all a_i[k]^b_i[k].
- g_o  output  1  block generate: the carry-out that would result with c_i=0.
- ov_o  output  1  signed overflow, equal to carry into the MSB XOR c_o.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Bit level, per bit k:
  - p[k] = a[k]^b[k]; g[k] = a[k]&b[k].
  - s[k] = p[k]^carry[k], with carry[0] = c_i.
- 4-bit group j:
  - Internal carries are the fully expanded lookahead equations, e.g. c2 = g1 | p1&g0 | p1&p0&cin.
  - Group signals: GP = p3&p2&p1&p0; GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
- Group lookahead unit: group carry-in Cj+1 = GGj | GPj&Cj, fully expanded, with C0 = c_i. Each group uses only its own Cj.
- c_o = C(WIDTH/4); p_o = AND of all GP; g_o = block GG with c_i excluded.
- Arithmetic:
  - Result is exact for all inputs: {c_o,s_o} == a_i + b_i + c_i as a (WIDTH+1)-bit unsigned value.
  - No saturation; the result wraps modulo 2^WIDTH in s_o, with c_o carrying bit WIDTH.
- Timing:
  - Inputs are sampled at the rising edge when valid_i=1.
  - s_o, c_o, p_o, g_o and ov_o update at that same edge and are visible the following cycle (latency 1).
  - valid_o is registered: valid_o <= valid_i every cycle.
  - When valid_i=0, the result registers hold their previous values and valid_o falls to 0.
  - There is no backpressure. Back-to-back valid_i yields one result per cycle.
- Reset:
  - rst_ni=0 immediately and asynchronously forces s_o=0, c_o=0, p_o=0, g_o=0, ov_o=0, valid_o=0, regardless of clock.
  - Deassertion takes effect at the next rising edge.
  - If reset asserts while valid_i=1, the in-flight operation is discarded.
- Boundaries:
  - All-ones + all-ones + 1 gives s_o = all-ones, c_o=1.
  - All-ones + 0 + 1 gives s_o=0, c_o=1, p_o=1, g_o=0.
- X on inputs with valid_i=0 must not propagate to the outputs.

Test Plan:
- Exhaustive, WIDTH=4: drive every {a_i,b_i,c_i} from 0 to 511 with valid_i=1, one per cycle. Each result one cycle later must satisfy {c_o,s_o} == a+b+c; e.g. a=9, b=8, c=1 gives c_o=1, s_o=2, and a=15, b=15, c=1 gives c_o=1, s_o=15.
- Propagate chain, WIDTH=16: a=16'hFFFF, b=0, c=1 -> s_o=0, c_o=1, p_o=1, g_o=0, ov_o=0.
- Signed overflow, WIDTH=4: a=7, b=1, c=0 -> s_o=8, c_o=0, ov_o=1. Also a=8, b=8, c=0 -> s_o=0, c_o=1, ov_o=1.
- Hold: issue a=3, b=4, c=0, then valid_i=0 for 3 cycles -> s_o stays 7, and valid_o is 1 for one cycle then 0.
- Async reset: mid-stream, pull rst_ni low between clock edges -> all outputs are 0 before the next edge. Release, send a=5, b=6, c=1 -> s_o=12 one cycle later.
- Random, WIDTH=8 and 12: at least 10k random valid/operand vectors against a reference model, including the c_i toggling edge cases.

Source files
------------

// File: rtl/carry_lookahead_adder4.sv
// Registered two-level carry-lookahead adder.
// Bits are grouped in fours. Each group forms its own carries with fully
// expanded lookahead equations. A group-level unit then forms every group
// carry-in directly from the group propagate/generate terms. Nothing ripples
// from one group to the next.

// One 4-bit lookahead group: local carries, sum bits and group P/G.
module cla_group4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c3_o,   // carry into bit 3, needed for signed overflow
  output logic       gp_o,
  output logic       gg_o
);
  logic [3:0] p, g, c;

  // Bit-level P/G, expanded in-group carries, and sums.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c;
    c3_o = c[3];
    gp_o = &p;
    gg_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

module carry_lookahead_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             p_o,
  output logic             g_o,
  output logic             ov_o
);
  localparam int NG = WIDTH / 4;

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 12 || WIDTH == 16)) begin : g_bad_width
    $error("carry_lookahead_adder4: WIDTH must be 4, 8, 12 or 16");
  end

  logic [NG-1:0]    gp, gg, c3;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum;
  logic             p_blk, g_blk;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q, p_d, p_q, g_d, g_q, ov_d, ov_q, valid_d, valid_q;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .a_i  (a_i[4*gi +: 4]),
      .b_i  (b_i[4*gi +: 4]),
      .c_i  (gc[gi]),
      .s_o  (sum[4*gi +: 4]),
      .c3_o (c3[gi]),
      .gp_o (gp[gi]),
      .gg_o (gg[gi])
    );
  end

  // Group lookahead: every C[j+1] is a flat sum of products over GG/GP and
  // c_i, so no group carry depends on another computed group carry.
  always_comb begin
    logic acc, term;
    gc    = '0;
    gc[0] = c_i;
    for (int j = 0; j < NG; j++) begin
      acc = c_i;
      for (int m = 0; m <= j; m++) acc &= gp[m];
      for (int k = 0; k <= j; k++) begin
        term = gg[k];
        for (int m = k + 1; m <= j; m++) term &= gp[m];
        acc |= term;
      end
      gc[j+1] = acc;
    end
    // Block generate is the same top-level carry with the c_i term left out.
    g_blk = 1'b0;
    for (int k = 0; k < NG; k++) begin
      term = gg[k];
      for (int m = k + 1; m < NG; m++) term &= gp[m];
      g_blk |= term;
    end
    p_blk = &gp;
  end

  // Next-state: capture a new result on valid_i, otherwise hold (so idle
  // operand values, even unknown ones, never reach the outputs).
  always_comb begin
    valid_d = valid_i;
    s_d     = s_q;
    c_d     = c_q;
    p_d     = p_q;
    g_d     = g_q;
    ov_d    = ov_q;
    if (valid_i) begin
      s_d  = sum;
      c_d  = gc[NG];
      p_d  = p_blk;
      g_d  = g_blk;
      ov_d = c3[NG-1] ^ gc[NG];
    end
  end

  // Result and valid registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s_q     <= s_d;
      c_q     <= c_d;
      p_q     <= p_d;
      g_q     <= g_d;
      ov_q    <= ov_d;
    end
  end

  assign valid_o = valid_q;
  assign s_o     = s_q;
  assign c_o     = c_q;
  assign p_o     = p_q;
  assign g_o     = g_q;
  assign ov_o    = ov_q;
endmodule

// File: tb/tb_carry_lookahead_adder4.sv
// Bench for carry_lookahead_adder4: four instances (WIDTH 4/8/12/16) share
// one operand stream; a queue scoreboard checks every cycle of every width,
// and a hand-computed vector table plus short sequences cover the corners.
module tb_carry_lookahead_adder4;
  typedef struct packed {
    logic [15:0] s;
    logic        c, p, g, ov;
  } res_t;

  typedef struct packed {
    logic [31:0]    cyc;
    logic           v;
    res_t [3:0]     e;
  } item_t;

  typedef struct packed {
    logic [1:0]  wi;
    logic [15:0] a, b;
    logic        c;
    res_t        e;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        c_i = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;

  res_t [3:0]  got;
  logic [3:0]  vo;

  item_t       q[$];
  res_t [3:0]  last = '0;
  logic [31:0] cyc = '0;
  bit          in_rst = 1'b1;
  int          nchecks = 0;
  int          nerr = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int W = 4 * (gi + 1);
    logic [W-1:0] s;
    logic         c, p, g, ov, v;
    carry_lookahead_adder4 #(.WIDTH(W)) u_dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .a_i     (a_i[W-1:0]),
      .b_i     (b_i[W-1:0]),
      .c_i     (c_i),
      .valid_o (v),
      .s_o     (s),
      .c_o     (c),
      .p_o     (p),
      .g_o     (g),
      .ov_o    (ov)
    );
    assign got[gi] = {16'(s), c, p, g, ov};
    assign vo[gi]  = v;
  end

  // Arithmetic reference: plain integer addition, masked to the width.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c);
    int unsigned mask, lm, av, bv, sum, cm;
    res_t r;
    mask = (32'd1 << w) - 32'd1;
    lm   = (32'd1 << (w - 1)) - 32'd1;
    av   = 32'(a) & mask;
    bv   = 32'(b) & mask;
    sum  = av + bv + 32'(c);
    cm   = ((av & lm) + (bv & lm) + 32'(c)) >> (w - 1);
    r.s  = 16'(sum & mask);
    r.c  = ((sum >> w) & 32'd1) != 0;
    r.p  = (av ^ bv) == mask;
    r.g  = (((av + bv) >> w) & 32'd1) != 0;
    r.ov = (cm[0]) ^ r.c;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [1:0] wi, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic [15:0] s, input logic co,
                               input logic p, input logic g, input logic ov);
    vec_t t;
    t.wi = wi; t.a = a; t.b = b; t.c = c;
    t.e  = {s, co, p, g, ov};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what every width should show next.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    item_t it;
    @(negedge clk_i);
    valid_i = v; a_i = a; b_i = b; c_i = c;
    if (v) for (int w = 0; w < 4; w++) last[w] = model(4 * (w + 1), a, b, c);
    it.cyc = cyc;
    it.v   = v;
    it.e   = last;
    q.push_back(it);
  endtask

  // Scoreboard: retire entries whose capturing edge has already passed.
  always @(negedge clk_i) begin
    if (!in_rst && q.size() > 0 && q[0].cyc < cyc) begin
      item_t it;
      it = q.pop_front();
      for (int w = 0; w < 4; w++)
        chk($sformatf("sb_w%0d", 4 * (w + 1)), 32'({got[w], vo[w]}), 32'({it.e[w], it.v}));
    end
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = mkv(0, 16'd9,  16'd8,  1'b1, 16'd2,  1'b1, 1'b0, 1'b1, 1'b1);
    tbl[1] = mkv(0, 16'd15, 16'd15, 1'b1, 16'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[2] = mkv(0, 16'd7,  16'd1,  1'b0, 16'd8,  1'b0, 1'b0, 1'b0, 1'b1);
    tbl[3] = mkv(0, 16'd8,  16'd8,  1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b1);
    tbl[4] = mkv(0, 16'd15, 16'd0,  1'b1, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5] = mkv(0, 16'd0,  16'd0,  1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6] = mkv(0, 16'd5,  16'd6,  1'b1, 16'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[7] = mkv(3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[8] = mkv(3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9] = mkv(1, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state.
    #2;
    for (int w = 0; w < 4; w++) chk("reset_state", 32'({got[w], vo[w]}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    in_rst = 1'b0;

    // Hand-computed vectors, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c);
      @(posedge clk_i); #1;
      chk($sformatf("tbl%0d", i), 32'({got[tbl[i].wi], vo[tbl[i].wi]}), 32'({tbl[i].e, 1'b1}));
    end

    // Exhaustive 4-bit sweep; upper bits random to exercise the wider DUTs.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      drive(1'b1, {12'($urandom), iv[8:5]}, {12'($urandom), iv[4:1]}, iv[0]);
    end

    // Hold: one valid result then three idle cycles with unknown operands.
    drive(1'b1, 16'd3, 16'd4, 1'b0);
    @(posedge clk_i); #1;
    chk("hold_first", 32'({got[0].s, vo[0]}), 32'({16'd7, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 'x, 'x, 1'bx);
      @(posedge clk_i); #1;
      chk($sformatf("hold_idle%0d", i), 32'({got[0].s, vo[0]}), 32'({16'd7, 1'b0}));
    end

    // Asynchronous reset between edges, with an operation in flight.
    drive(1'b1, 16'h1234, 16'h4321, 1'b1);
    drive(1'b1, 16'hABCD, 16'h0F0F, 1'b0);
    @(posedge clk_i); #3;
    in_rst = 1'b1;
    rst_ni = 1'b0;
    q.delete();
    last = '0;
    #1;
    for (int w = 0; w < 4; w++) chk("async_rst", 32'({got[w], vo[w]}), 32'd0);
    @(posedge clk_i); #1;
    for (int w = 0; w < 4; w++) chk("rst_held", 32'({got[w], vo[w]}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    valid_i = 1'b0;
    in_rst = 1'b0;
    drive(1'b1, 16'd5, 16'd6, 1'b1);
    @(posedge clk_i); #1;
    chk("rst_recover", 32'({got[0].s, got[0].c, vo[0]}), 32'({16'd12, 1'b0, 1'b1}));

    // Random traffic, with carry-in toggling on full-propagate operands.
    for (int n = 0; n < 10000; n++) begin
      logic [15:0] a, b;
      logic        c, v;
      int          mode;
      mode = $urandom_range(0, 3);
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (mode == 0) begin b = ~a; c = n[0]; end
      if (mode == 1) begin a = 16'hFFFF; b = 16'h0000; c = n[0]; end
      v = ($urandom_range(0, 9) != 0);
      drive(v, a, b, c);
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 16'd0, 16'd0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
